// File: rtl/two_way_demux_reg.sv
// Registered 1-to-2 demultiplexer with per-lane one-entry output registers and valid/ready.
// Optional broadcast input enabled by defining TWO_WAY_DEMUX_BCAST_EN.
module two_way_demux_reg #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_in,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic                 i_op,
`ifdef TWO_WAY_DEMUX_BCAST_EN
  input  logic                 i_bcast,
`endif
  output logic [WIDTH-1:0]     o_out0,
  output logic                 o_out0_valid,
  input  logic                 i_out0_ready,
  output logic [WIDTH-1:0]     o_out1,
  output logic                 o_out1_valid,
  input  logic                 i_out1_ready,
  output logic [CNT_WIDTH-1:0] o_cnt0,
  output logic [CNT_WIDTH-1:0] o_cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  lane_state_t          r_state0;
  lane_state_t          r_state1;
  logic [WIDTH-1:0]     r_out0;
  logic [WIDTH-1:0]     r_out1;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  logic w_can_load0;
  logic w_can_load1;
  logic w_drain0;
  logic w_drain1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  assign w_can_load0 = (r_state0 == EMPTY) | i_out0_ready;
  assign w_can_load1 = (r_state1 == EMPTY) | i_out1_ready;
  assign w_drain0    = (r_state0 == FULL) & i_out0_ready;
  assign w_drain1    = (r_state1 == FULL) & i_out1_ready;
  assign w_accept    = i_in_valid & o_in_ready;

  // in_ready is forced low while reset is held so no word is accepted into a clearing lane.
`ifdef TWO_WAY_DEMUX_BCAST_EN
  assign o_in_ready = !i_rst & (i_bcast ? (w_can_load0 & w_can_load1)
                                        : (i_op ? w_can_load1 : w_can_load0));
  assign w_load0    = w_accept & (i_bcast | !i_op);
  assign w_load1    = w_accept & (i_bcast | i_op);
`else
  assign o_in_ready = !i_rst & (i_op ? w_can_load1 : w_can_load0);
  assign w_load0    = w_accept & !i_op;
  assign w_load1    = w_accept & i_op;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state0 <= EMPTY;
      r_out0   <= '0;
      r_cnt0   <= '0;
    end else begin
      if (w_drain0) begin
        r_cnt0 <= r_cnt0 + CNT_ONE;
      end
      case (r_state0)
        EMPTY: begin
          if (w_load0) begin
            r_state0 <= FULL;
            r_out0   <= i_in;
          end
        end
        FULL: begin
          // A load in the drain cycle replaces the word without a bubble.
          if (w_load0) begin
            r_out0 <= i_in;
          end else if (w_drain0) begin
            r_state0 <= EMPTY;
          end
        end
        default: r_state0 <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state1 <= EMPTY;
      r_out1   <= '0;
      r_cnt1   <= '0;
    end else begin
      if (w_drain1) begin
        r_cnt1 <= r_cnt1 + CNT_ONE;
      end
      case (r_state1)
        EMPTY: begin
          if (w_load1) begin
            r_state1 <= FULL;
            r_out1   <= i_in;
          end
        end
        FULL: begin
          if (w_load1) begin
            r_out1 <= i_in;
          end else if (w_drain1) begin
            r_state1 <= EMPTY;
          end
        end
        default: r_state1 <= EMPTY;
      endcase
    end
  end

  assign o_out0       = r_out0;
  assign o_out1       = r_out1;
  assign o_out0_valid = (r_state0 == FULL);
  assign o_out1_valid = (r_state1 == FULL);
  assign o_cnt0       = r_cnt0;
  assign o_cnt1       = r_cnt1;

endmodule

// File: tb/tb_two_way_demux_reg.sv
// Directed testbench for two_way_demux_reg: vector table plus hand-written multi-cycle sequences.
// Broadcast sequence is included when TWO_WAY_DEMUX_BCAST_EN is defined.
module tb_two_way_demux_reg;

  typedef struct {
    logic        iv;
    logic        op;
    logic [15:0] din;
    logic        r0;
    logic        r1;
    logic        expRdy;
    logic [15:0] expOut0;
    logic        expV0;
    logic [15:0] expOut1;
    logic        expV1;
    logic [7:0]  expCnt0;
    logic [7:0]  expCnt1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic        op = 1'b0;
  logic        bcast = 1'b0;
  logic [15:0] out0;
  logic        out0Valid;
  logic        out0Ready = 1'b1;
  logic [15:0] out1;
  logic        out1Valid;
  logic        out1Ready = 1'b1;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int checks = 0;
  int failures = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  two_way_demux_reg #(.WIDTH(16), .CNT_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in         (din),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_op         (op),
`ifdef TWO_WAY_DEMUX_BCAST_EN
    .i_bcast      (bcast),
`endif
    .o_out0       (out0),
    .o_out0_valid (out0Valid),
    .i_out0_ready (out0Ready),
    .o_out1       (out1),
    .o_out1_valid (out1Valid),
    .i_out1_ready (out1Ready),
    .o_cnt0       (cnt0),
    .o_cnt1       (cnt1)
  );

  function automatic vec_t mkVec(logic iv, logic o, logic [15:0] d, logic r0, logic r1,
                                 logic rdy, logic [15:0] o0, logic v0, logic [15:0] o1,
                                 logic v1, logic [7:0] c0, logic [7:0] c1);
    vec_t v;
    v.iv = iv; v.op = o; v.din = d; v.r0 = r0; v.r1 = r1;
    v.expRdy = rdy; v.expOut0 = o0; v.expV0 = v0; v.expOut1 = o1; v.expV1 = v1;
    v.expCnt0 = c0; v.expCnt1 = c1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    inValid   = v.iv;
    op        = v.op;
    din       = v.din;
    out0Ready = v.r0;
    out1Ready = v.r1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [15:0] o0, input logic v0,
                            input logic [15:0] o1, input logic v1,
                            input logic [7:0] c0, input logic [7:0] c1);
    checkOutput({tag, " out0"}, 32'(out0), 32'(o0));
    checkOutput({tag, " out0_valid"}, 32'(out0Valid), 32'(v0));
    checkOutput({tag, " out1"}, 32'(out1), 32'(o1));
    checkOutput({tag, " out1_valid"}, 32'(out1Valid), 32'(v1));
    checkOutput({tag, " cnt0"}, 32'(cnt0), 32'(c0));
    checkOutput({tag, " cnt1"}, 32'(cnt1), 32'(c1));
  endtask

  initial begin
    // iv op din r0 r1 | rdy out0 v0 out1 v1 cnt0 cnt1
    vecs[0]  = mkVec(1, 0, 16'h0000, 1, 1, 1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    vecs[1]  = mkVec(1, 1, 16'h0001, 1, 1, 1, 16'h0000, 0, 16'h0001, 1, 1, 0);
    vecs[2]  = mkVec(0, 0, 16'h0000, 1, 1, 1, 16'h0000, 0, 16'h0001, 0, 1, 1);
    vecs[3]  = mkVec(1, 0, 16'hAAAA, 0, 1, 1, 16'hAAAA, 1, 16'h0001, 0, 1, 1);
    vecs[4]  = mkVec(1, 0, 16'hBBBB, 0, 1, 0, 16'hAAAA, 1, 16'h0001, 0, 1, 1);
    vecs[5]  = mkVec(1, 1, 16'hBBBB, 0, 0, 1, 16'hAAAA, 1, 16'hBBBB, 1, 1, 1);
    vecs[6]  = mkVec(1, 1, 16'hCCCC, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 1, 1);
    vecs[7]  = mkVec(1, 0, 16'hDDDD, 1, 0, 1, 16'hDDDD, 1, 16'hBBBB, 1, 2, 1);
    vecs[8]  = mkVec(0, 0, 16'h0000, 1, 1, 1, 16'hDDDD, 0, 16'hBBBB, 0, 3, 2);
    vecs[9]  = mkVec(1, 0, 16'h0001, 1, 1, 1, 16'h0001, 1, 16'hBBBB, 0, 3, 2);
    vecs[10] = mkVec(1, 0, 16'h0002, 1, 1, 1, 16'h0002, 1, 16'hBBBB, 0, 4, 2);
    vecs[11] = mkVec(1, 0, 16'h0003, 1, 1, 1, 16'h0003, 1, 16'hBBBB, 0, 5, 2);
    vecs[12] = mkVec(1, 0, 16'h0004, 1, 1, 1, 16'h0004, 1, 16'hBBBB, 0, 6, 2);
    vecs[13] = mkVec(0, 0, 16'h0000, 1, 1, 1, 16'h0004, 0, 16'hBBBB, 0, 7, 2);

    // Reset held for 10 cycles with a word offered and all consumers ready.
    inValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset c%0d in_ready", c), 32'(inReady), 32'd0);
    end
    checkState("reset", 16'h0, 1'b0, 16'h0, 1'b0, 8'd0, 8'd0);
    inValid = 1'b0;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 32'(inReady), 32'(vecs[i].expRdy));
      @(posedge clk);
      #1;
      checkState($sformatf("v%0d", i), vecs[i].expOut0, vecs[i].expV0,
                 vecs[i].expOut1, vecs[i].expV1, vecs[i].expCnt0, vecs[i].expCnt1);
    end

    // Lane 1 counter wrap: starts at 2, 254 drains bring it to 0 with a word still held.
    inValid   = 1'b1;
    op        = 1'b1;
    out0Ready = 1'b1;
    out1Ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      din = 16'(k);
      @(posedge clk);
      #1;
      if (k == 253) checkOutput("wrap cnt1 at 255", 32'(cnt1), 32'd255);
    end
    checkOutput("wrap cnt1 to 0", 32'(cnt1), 32'd0);
    checkOutput("wrap out1_valid", 32'(out1Valid), 32'd1);
    checkOutput("wrap out1", 32'(out1), 32'd254);
    checkOutput("wrap cnt0 unchanged", 32'(cnt0), 32'd7);

    // Mid-cycle reset pulse discards the held lane 1 word immediately.
    inValid   = 1'b0;
    out1Ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset out1_valid", 32'(out1Valid), 32'd0);
    checkOutput("async reset in_ready", 32'(inReady), 32'd0);
    checkState("async reset", 16'h0, 1'b0, 16'h0, 1'b0, 8'd0, 8'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef TWO_WAY_DEMUX_BCAST_EN
    // Broadcast loads both lanes; the next one waits for the stalled lane 1.
    bcast     = 1'b1;
    op        = 1'b0;
    inValid   = 1'b1;
    din       = 16'h1234;
    out0Ready = 1'b1;
    out1Ready = 1'b0;
    #1;
    checkOutput("bcast1 in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    checkState("bcast1", 16'h1234, 1'b1, 16'h1234, 1'b1, 8'd0, 8'd0);
    din = 16'h5678;
    #1;
    checkOutput("bcast2 stall in_ready", 32'(inReady), 32'd0);
    @(posedge clk);
    #1;
    checkState("bcast2 stall", 16'h1234, 1'b0, 16'h1234, 1'b1, 8'd1, 8'd0);
    out1Ready = 1'b1;
    #1;
    checkOutput("bcast2 release in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    #1;
    checkState("bcast2 release", 16'h5678, 1'b1, 16'h5678, 1'b1, 8'd1, 8'd1);
    inValid = 1'b0;
    bcast   = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
